// File: rtl/aes_pkg.sv
// Shared types, round constants and the S-box table for the AES key schedule engine.
// Build option AES_KS_SBOX_PIPE_EN (see aes_key_schedule_seq) does not affect this package.
package aes_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned RK_W   = 128;
    localparam int unsigned NK_W   = 4;

    typedef enum logic [1:0] {
        AES128 = 2'b00,
        AES192 = 2'b01,
        AES256 = 2'b10
    } aes_mode_e;

    localparam logic [NK_W-1:0] NK [3] = '{4'd4, 4'd6, 4'd8};
    localparam logic [NK_W-1:0] NR [3] = '{4'd10, 4'd12, 4'd14};

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [NK_W-1:0] nk_of(input aes_mode_e m);
        case (m)
            AES192:  return NK[1];
            AES256:  return NK[2];
            default: return NK[0];
        endcase
    endfunction

    function automatic logic [NK_W-1:0] nr_of(input aes_mode_e m);
        case (m)
            AES192:  return NR[1];
            AES256:  return NR[2];
            default: return NR[0];
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: four parallel byte S-box lookups on a 32-bit word (combinational).
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] sub_c
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign sub_c[8*b +: 8] = SBOX[word[8*b +: 8]];
    end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion, one schedule word per cycle, round keys on valid/ready.
// Build option AES_KS_SBOX_PIPE_EN registers the SubWord result (S-box words take two cycles).
module aes_key_schedule_seq
    import aes_pkg::*;
#(
    parameter int unsigned NK_MAX = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [32*NK_MAX-1:0]     key_in,
    output logic                     busy,
    output logic                     err,
    output logic                     rk_valid,
    input  logic                     rk_ready,
    output logic [RK_W-1:0]          rk_data,
    output logic [IDX_W-1:0]         rk_idx,
    output logic                     done
);

    localparam int unsigned WCNT_W  = 6;
    localparam int unsigned HIST_AW = $clog2(NK_MAX);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_GEN  = 1'b1
    } state_e;

    state_e               state;
    state_e               state_next;
    aes_mode_e            mode_q;
    logic [32*NK_MAX-1:0] key_q;
    logic [WORD_W-1:0]    hist [NK_MAX];
    logic [WORD_W-1:0]    asm_q [3];
    logic [WCNT_W-1:0]    wcnt;
    logic [HIST_AW-1:0]   jcnt;
    logic [1:0]           acnt;
    logic [7:0]           rcon;
    logic [IDX_W-1:0]     ld_cnt;

    logic                 start_ok;
    logic                 err_set;
    logic                 finish;
    logic [NK_W-1:0]      nk;
    logic [NK_W-1:0]      nr;
    logic [WCNT_W-1:0]    words_total;
    logic                 all_gen;
    logic                 key_phase;
    logic                 need_sbox;
    logic                 word_ok;
    logic                 stall;
    logic                 hs;
    logic                 last_hs;
    logic                 gen_en;
    logic                 load_out;
    logic [WORD_W-1:0]    key_w [NK_MAX];
    logic [WORD_W-1:0]    w_nk;
    logic [WORD_W-1:0]    sbox_in;
    logic [WORD_W-1:0]    sub_c;
    logic [WORD_W-1:0]    sub_use;
    logic [WORD_W-1:0]    word;

    assign nk          = nk_of(mode_q);
    assign nr          = nr_of(mode_q);
    assign words_total = {nr, 2'b00} + WCNT_W'(4);
    assign all_gen     = (wcnt == words_total);
    assign key_phase   = (wcnt < WCNT_W'(nk));
    assign need_sbox   = !key_phase && !all_gen &&
                         ((jcnt == '0) || ((nk == NK_W'(8)) && (jcnt == HIST_AW'(4))));

    // Generation may only run ahead by the assembly depth; a held output word blocks the 4th.
    assign hs       = rk_valid && rk_ready;
    assign stall    = (acnt == 2'd3) && rk_valid && !rk_ready;
    assign last_hs  = hs && (rk_idx == IDX_W'(nr));
    assign gen_en   = (state == S_GEN) && !all_gen && !stall && word_ok;
    assign load_out = gen_en && (acnt == 2'd3);

    always_comb begin
        for (int k = 0; k < NK_MAX; k++) begin
            key_w[k] = key_q[32*(NK_MAX-1-k) +: 32];
        end
    end

    always_comb begin
        case (mode_q)
            AES192:  w_nk = hist[5];
            AES256:  w_nk = hist[7];
            default: w_nk = hist[3];
        endcase
    end

    assign sbox_in = (jcnt == '0) ? {hist[0][23:0], hist[0][31:24]} : hist[0];

    aes_sbox_word u_sbox (
        .word  (sbox_in),
        .sub_c (sub_c)
    );

`ifdef AES_KS_SBOX_PIPE_EN
    logic [WORD_W-1:0] sub_q;
    logic              sub_vld;

    // First cycle of an S-box word captures SubWord; the word is emitted the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q   <= '0;
            sub_vld <= 1'b0;
        end else if (start_ok || gen_en) begin
            sub_vld <= 1'b0;
        end else if ((state == S_GEN) && need_sbox && !sub_vld) begin
            sub_q   <= sub_c;
            sub_vld <= 1'b1;
        end
    end

    assign sub_use = sub_q;
    assign word_ok = !need_sbox || sub_vld;
`else
    assign sub_use = sub_c;
    assign word_ok = 1'b1;
`endif

    always_comb begin
        word = w_nk ^ hist[0];
        if (key_phase) begin
            word = key_w[wcnt[HIST_AW-1:0]];
        end else if (jcnt == '0) begin
            word = w_nk ^ sub_use ^ {rcon, 24'h000000};
        end else if (need_sbox) begin
            word = w_nk ^ sub_use;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        err_set    = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (mode == 2'b11) begin
                        err_set = 1'b1;
                    end else begin
                        start_ok   = 1'b1;
                        state_next = S_GEN;
                    end
                end
            end
            S_GEN: begin
                if (last_hs) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Word generation: history, counters, Rcon and the assembly shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= AES128;
            key_q  <= '0;
            wcnt   <= '0;
            jcnt   <= '0;
            acnt   <= '0;
            rcon   <= 8'h00;
            for (int k = 0; k < NK_MAX; k++) hist[k] <= '0;
            for (int k = 0; k < 3; k++) asm_q[k] <= '0;
        end else if (start_ok) begin
            mode_q <= aes_mode_e'(mode);
            key_q  <= key_in;
            wcnt   <= '0;
            jcnt   <= '0;
            acnt   <= '0;
            rcon   <= 8'h01;
            for (int k = 0; k < NK_MAX; k++) hist[k] <= '0;
        end else if (gen_en) begin
            hist[0] <= word;
            for (int k = 1; k < NK_MAX; k++) hist[k] <= hist[k-1];
            asm_q[0] <= word;
            asm_q[1] <= asm_q[0];
            asm_q[2] <= asm_q[1];
            acnt     <= acnt + 2'd1;
            wcnt     <= wcnt + WCNT_W'(1);
            jcnt     <= (NK_W'(jcnt) == nk - NK_W'(1)) ? '0 : jcnt + HIST_AW'(1);
            if (!key_phase && (jcnt == '0)) begin
                rcon <= xtime(rcon);
            end
        end
    end

    // Output register and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_idx   <= '0;
            ld_cnt   <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            err  <= err_set;
            done <= finish;
            if (start_ok) begin
                busy   <= 1'b1;
                ld_cnt <= '0;
            end else if (finish) begin
                busy <= 1'b0;
            end
            if (load_out) begin
                rk_valid <= 1'b1;
                rk_data  <= {asm_q[2], asm_q[1], asm_q[0], word};
                rk_idx   <= ld_cnt;
                ld_cnt   <= ld_cnt + IDX_W'(1);
            end else if (hs) begin
                rk_valid <= 1'b0;
            end
        end
    end

endmodule
